// File: rtl/rvfi_check_pkg.sv
// rtl/rvfi_check_pkg.sv - shared types and helpers for the RVFI reorder checkers
package rvfi_check_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int ORDER_W_DEF = 8;

    typedef struct packed {
        logic                vld;
        logic [XLEN_DEF-1:0] pre_pc;
        logic [XLEN_DEF-1:0] post_pc;
    } slot_t;

    // Forward distance from b to a on a w-bit modular order counter.
    function automatic logic [31:0] order_dist(input logic [31:0] a, input logic [31:0] b,
                                               input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/rvfi_order_window.sv
// rtl/rvfi_order_window.sv - reorder slot array with NRET write ports and in-order read window
module rvfi_order_window
    import rvfi_check_pkg::*;
#(
    parameter int NRET  = 1,
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NRET-1:0]            wr_en,
    input  logic [NRET-1:0][IDX_W-1:0] wr_idx,
    input  logic [NRET-1:0][XLEN-1:0]  wr_pre_pc,
    input  logic [NRET-1:0][XLEN-1:0]  wr_post_pc,
    input  logic [DEPTH-1:0]           drain_clr,
    input  logic [IDX_W-1:0]           rd_base,
    output logic [DEPTH-1:0]           slot_vld,
    output logic [NRET-1:0]            rd_vld,
    output logic [NRET-1:0][XLEN-1:0]  rd_pre_pc,
    output logic [NRET-1:0][XLEN-1:0]  rd_post_pc
);

    slot_t slot_q [DEPTH];
    slot_t slot_d [DEPTH];

    // Clears are applied before writes so a slot freed this cycle can be refilled.
    always_comb begin
        for (int d = 0; d < DEPTH; d++) begin
            slot_d[d] = slot_q[d];
            if (drain_clr[d]) begin
                slot_d[d].vld = 1'b0;
            end
        end
        for (int c = 0; c < NRET; c++) begin
            if (wr_en[c]) begin
                slot_d[wr_idx[c]] = '{vld:     1'b1,
                                      pre_pc:  XLEN_DEF'(wr_pre_pc[c]),
                                      post_pc: XLEN_DEF'(wr_post_pc[c])};
            end
        end
    end

    always_comb begin
        logic [IDX_W-1:0] ri;
        ri = '0;
        for (int d = 0; d < DEPTH; d++) begin
            slot_vld[d] = slot_q[d].vld;
        end
        for (int c = 0; c < NRET; c++) begin
            ri            = rd_base + IDX_W'(c);
            rd_vld[c]     = slot_q[ri].vld;
            rd_pre_pc[c]  = XLEN'(slot_q[ri].pre_pc);
            rd_post_pc[c] = XLEN'(slot_q[ri].post_pc);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int d = 0; d < DEPTH; d++) begin
                slot_q[d] <= '0;
            end
        end else begin
            for (int d = 0; d < DEPTH; d++) begin
                slot_q[d] <= slot_d[d];
            end
        end
    end

endmodule

// File: rtl/rvfi_pc_reorder_check.sv
// rtl/rvfi_pc_reorder_check.sv - PC continuity checker tolerant of out-of-order RVFI retirement
module rvfi_pc_reorder_check
    import rvfi_check_pkg::*;
#(
    parameter int NRET    = 1,
    parameter int XLEN    = XLEN_DEF,
    parameter int ORDER_W = ORDER_W_DEF,
    parameter int DEPTH   = 4,
    parameter int IALIGN  = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NRET-1:0]              rvfi_valid,
    input  logic [NRET*ORDER_W-1:0]      rvfi_order,
    input  logic [NRET*XLEN-1:0]         rvfi_pre_pc,
    input  logic [NRET*XLEN-1:0]         rvfi_post_pc,
    input  logic [NRET-1:0]              rvfi_trap,
    output logic                         err_pc,
    output logic                         err_order,
    output logic                         err_dup,
    output logic                         err_align,
    output logic [ORDER_W-1:0]           err_at,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ORDER_W-1:0] next_order_q, next_order_d;
    logic [XLEN-1:0]    pc_shadow_q, pc_shadow_d;
    logic               pc_written_q, pc_written_d;
    logic               err_pc_q, err_pc_d;
    logic               err_order_q, err_order_d;
    logic               err_dup_q, err_dup_d;
    logic               err_align_q, err_align_d;
    logic [ORDER_W-1:0] err_at_q, err_at_d;
    logic [CNT_W-1:0]   pending_q, pending_d;

    logic [NRET-1:0]            wr_en;
    logic [NRET-1:0][IDX_W-1:0] wr_idx;
    logic [NRET-1:0][XLEN-1:0]  wr_pre_pc, wr_post_pc;
    logic [DEPTH-1:0]           drain_clr;
    logic [DEPTH-1:0]           slot_vld;
    logic [NRET-1:0]            rd_vld;
    logic [NRET-1:0][XLEN-1:0]  rd_pre_pc, rd_post_pc;

    logic [NRET-1:0]    ev_order, ev_dup, ev_align;
    logic               ev_pc;
    logic [ORDER_W-1:0] ev_pc_order;
    logic [CNT_W-1:0]   n_wr, n_drain;

    rvfi_order_window #(
        .NRET  (NRET),
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_window (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_pre_pc  (wr_pre_pc),
        .wr_post_pc (wr_post_pc),
        .drain_clr  (drain_clr),
        .rd_base    (next_order_q[IDX_W-1:0]),
        .slot_vld   (slot_vld),
        .rd_vld     (rd_vld),
        .rd_pre_pc  (rd_pre_pc),
        .rd_post_pc (rd_post_pc)
    );

    always_comb begin
        logic [ORDER_W-1:0] ord_c;
        logic [XLEN-1:0]    post_c;
        logic               dup;
        wr_en      = '0;
        wr_idx     = '0;
        wr_pre_pc  = '0;
        wr_post_pc = '0;
        ev_order   = '0;
        ev_dup     = '0;
        ev_align   = '0;
        n_wr       = '0;
        ord_c      = '0;
        post_c     = '0;
        dup        = 1'b0;
        for (int c = 0; c < NRET; c++) begin
            ord_c         = rvfi_order[c*ORDER_W +: ORDER_W];
            post_c        = rvfi_post_pc[c*XLEN +: XLEN];
            wr_idx[c]     = ord_c[IDX_W-1:0];
            wr_pre_pc[c]  = rvfi_pre_pc[c*XLEN +: XLEN];
            wr_post_pc[c] = post_c;
            if (rvfi_valid[c]) begin
                if (order_dist(32'(ord_c), 32'(next_order_q), ORDER_W) >= 32'(DEPTH)) begin
                    ev_order[c] = 1'b1;
                end else begin
                    dup = slot_vld[wr_idx[c]];
                    for (int j = 0; j < c; j++) begin
                        if (rvfi_valid[j] && (rvfi_order[j*ORDER_W +: ORDER_W] == ord_c)) begin
                            dup = 1'b1;
                        end
                    end
                    if (dup) begin
                        ev_dup[c] = 1'b1;
                    end else begin
                        wr_en[c] = 1'b1;
                        n_wr     = n_wr + CNT_W'(1);
                        if (!rvfi_trap[c] &&
                            ((IALIGN == 2) ? post_c[0] : (post_c[0] | post_c[1]))) begin
                            ev_align[c] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Drain walks the window in order; each entry sees the previous entry's post_pc.
    always_comb begin
        logic active;
        next_order_d = next_order_q;
        pc_shadow_d  = pc_shadow_q;
        pc_written_d = pc_written_q;
        drain_clr    = '0;
        ev_pc        = 1'b0;
        ev_pc_order  = '0;
        n_drain      = '0;
        active       = 1'b1;
        for (int k = 0; k < NRET; k++) begin
            if (active && rd_vld[k]) begin
                if (pc_written_d && (pc_shadow_d != rd_pre_pc[k])) begin
                    if (!ev_pc) begin
                        ev_pc_order = next_order_d;
                    end
                    ev_pc = 1'b1;
                end
                pc_shadow_d  = rd_post_pc[k];
                pc_written_d = 1'b1;
                drain_clr[next_order_d[IDX_W-1:0]] = 1'b1;
                next_order_d = next_order_d + ORDER_W'(1);
                n_drain      = n_drain + CNT_W'(1);
            end else begin
                active = 1'b0;
            end
        end
    end

    always_comb begin
        logic               ev_any;
        logic [ORDER_W-1:0] ev_at;
        ev_any = ev_pc;
        ev_at  = ev_pc_order;
        for (int c = NRET-1; c >= 0; c--) begin
            if (ev_order[c] || ev_dup[c] || ev_align[c]) begin
                ev_any = 1'b1;
                ev_at  = rvfi_order[c*ORDER_W +: ORDER_W];
            end
        end
        err_pc_d    = err_pc_q | ev_pc;
        err_order_d = err_order_q | (|ev_order);
        err_dup_d   = err_dup_q | (|ev_dup);
        err_align_d = err_align_q | (|ev_align);
        err_at_d    = err_at_q;
        if (!(err_pc_q || err_order_q || err_dup_q || err_align_q) && ev_any) begin
            err_at_d = ev_at;
        end
        pending_d = pending_q + n_wr - n_drain;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            next_order_q <= '0;
            pc_shadow_q  <= '0;
            pc_written_q <= 1'b0;
            err_pc_q     <= 1'b0;
            err_order_q  <= 1'b0;
            err_dup_q    <= 1'b0;
            err_align_q  <= 1'b0;
            err_at_q     <= '0;
            pending_q    <= '0;
        end else begin
            next_order_q <= next_order_d;
            pc_shadow_q  <= pc_shadow_d;
            pc_written_q <= pc_written_d;
            err_pc_q     <= err_pc_d;
            err_order_q  <= err_order_d;
            err_dup_q    <= err_dup_d;
            err_align_q  <= err_align_d;
            err_at_q     <= err_at_d;
            pending_q    <= pending_d;
        end
    end

    assign err_pc    = err_pc_q;
    assign err_order = err_order_q;
    assign err_dup   = err_dup_q;
    assign err_align = err_align_q;
    assign err_at    = err_at_q;
    assign pending   = pending_q;

`ifdef FORMAL
    always_comb begin
        if (resetn) begin
            assert (!err_pc && !err_order && !err_dup && !err_align);
        end
    end
`endif

endmodule

// File: tb/tb_rvfi_pc_reorder_check.sv
// tb/tb_rvfi_pc_reorder_check.sv - directed table-driven bench for rvfi_pc_reorder_check
module tb_rvfi_pc_reorder_check;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  rvfi_valid;
    logic [15:0] rvfi_order;
    logic [63:0] rvfi_pre_pc;
    logic [63:0] rvfi_post_pc;
    logic [1:0]  rvfi_trap;
    logic        err_pc, err_order, err_dup, err_align;
    logic [7:0]  err_at;
    logic [2:0]  pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rvfi_pc_reorder_check #(
        .NRET    (2),
        .XLEN    (32),
        .ORDER_W (8),
        .DEPTH   (4),
        .IALIGN  (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rvfi_valid   (rvfi_valid),
        .rvfi_order   (rvfi_order),
        .rvfi_pre_pc  (rvfi_pre_pc),
        .rvfi_post_pc (rvfi_post_pc),
        .rvfi_trap    (rvfi_trap),
        .err_pc       (err_pc),
        .err_order    (err_order),
        .err_dup      (err_dup),
        .err_align    (err_align),
        .err_at       (err_at),
        .pending      (pending)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [7:0]  o0;
        logic [31:0] pre0, post0;
        logic [7:0]  o1;
        logic [31:0] pre1, post1;
        logic [1:0]  trap;
        logic [3:0]  eflags;
        logic [7:0]  eat;
        logic [2:0]  epend;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic [1:0] v,
                                input logic [7:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [7:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic [1:0] tr, input logic [3:0] ef,
                                input logic [7:0] ea, input logic [2:0] ep);
        vec_t t;
        t.rst = r; t.vld = v; t.o0 = o0; t.pre0 = a0; t.post0 = b0;
        t.o1 = o1; t.pre1 = a1; t.post1 = b1; t.trap = tr;
        t.eflags = ef; t.eat = ea; t.epend = ep;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] o0, input logic [31:0] a0,
                         input logic [31:0] b0, input logic [7:0] o1, input logic [31:0] a1,
                         input logic [31:0] b1, input logic [1:0] tr);
        rvfi_valid   = v;
        rvfi_order   = {o1, o0};
        rvfi_pre_pc  = {a1, a0};
        rvfi_post_pc = {b1, b0};
        rvfi_trap    = tr;
    endtask

    task automatic idle();
        drive(2'b00, 8'd0, 32'd0, 32'd0, 8'd0, 32'd0, 32'd0, 2'b00);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    function automatic logic [3:0] flags();
        return {err_pc, err_order, err_dup, err_align};
    endfunction

    initial begin
        // flags field: {pc, order, dup, align}
        vq.push_back(mk(0, 2'b01, 0, 32'h0,  32'h4,  0, 0, 0, 2'b00, 4'b0000, 0, 1));
        vq.push_back(mk(0, 2'b01, 1, 32'h4,  32'h8,  0, 0, 0, 2'b00, 4'b0000, 0, 1));
        vq.push_back(mk(0, 2'b01, 2, 32'h8,  32'hC,  0, 0, 0, 2'b00, 4'b0000, 0, 1));
        vq.push_back(mk(0, 2'b00, 0, 0, 0,            0, 0, 0, 2'b00, 4'b0000, 0, 0));
        vq.push_back(mk(1, 2'b11, 1, 32'h4,  32'h8,  0, 32'h0, 32'h4, 2'b00, 4'b0000, 0, 2));
        vq.push_back(mk(0, 2'b00, 0, 0, 0,            0, 0, 0, 2'b00, 4'b0000, 0, 0));
        vq.push_back(mk(0, 2'b11, 2, 32'h8,  32'hC,  5, 32'h14, 32'h18, 2'b00, 4'b0000, 0, 2));
        vq.push_back(mk(0, 2'b00, 0, 0, 0,            0, 0, 0, 2'b00, 4'b0000, 0, 1));
        vq.push_back(mk(0, 2'b01, 3, 32'hC,  32'h10, 0, 0, 0, 2'b00, 4'b0000, 0, 2));
        vq.push_back(mk(0, 2'b00, 0, 0, 0,            0, 0, 0, 2'b00, 4'b0000, 0, 1));
        vq.push_back(mk(0, 2'b01, 4, 32'h10, 32'h14, 0, 0, 0, 2'b00, 4'b0000, 0, 2));
        vq.push_back(mk(0, 2'b00, 0, 0, 0,            0, 0, 0, 2'b00, 4'b0000, 0, 0));
        vq.push_back(mk(1, 2'b01, 0, 32'h0,  32'h4,  0, 0, 0, 2'b00, 4'b0000, 0, 1));
        vq.push_back(mk(0, 2'b01, 1, 32'h10, 32'h14, 0, 0, 0, 2'b00, 4'b0000, 0, 1));
        vq.push_back(mk(0, 2'b00, 0, 0, 0,            0, 0, 0, 2'b00, 4'b1000, 1, 0));
        vq.push_back(mk(0, 2'b01, 9, 32'h0,  32'h0,  0, 0, 0, 2'b00, 4'b1100, 1, 0));
        vq.push_back(mk(1, 2'b01, 4, 32'h0,  32'h0,  0, 0, 0, 2'b00, 4'b0100, 4, 0));
        vq.push_back(mk(0, 2'b01, 2, 32'h100, 32'h104, 0, 0, 0, 2'b00, 4'b0100, 4, 1));
        vq.push_back(mk(0, 2'b01, 2, 32'h200, 32'h204, 0, 0, 0, 2'b00, 4'b0110, 4, 1));
        vq.push_back(mk(0, 2'b11, 0, 32'hF0, 32'hF8, 1, 32'hF8, 32'h100, 2'b00, 4'b0110, 4, 3));
        vq.push_back(mk(0, 2'b00, 0, 0, 0,            0, 0, 0, 2'b00, 4'b0110, 4, 1));
        vq.push_back(mk(0, 2'b00, 0, 0, 0,            0, 0, 0, 2'b00, 4'b0110, 4, 0));
        vq.push_back(mk(1, 2'b11, 1, 32'h10, 32'h14, 1, 32'h40, 32'h44, 2'b00, 4'b0010, 1, 1));
        vq.push_back(mk(0, 2'b00, 0, 0, 0,            0, 0, 0, 2'b00, 4'b0010, 1, 1));
        vq.push_back(mk(1, 2'b01, 0, 32'h0,    32'h1002, 0, 0, 0, 2'b01, 4'b0000, 0, 1));
        vq.push_back(mk(0, 2'b01, 1, 32'h1002, 32'h1006, 0, 0, 0, 2'b00, 4'b0001, 1, 1));
        vq.push_back(mk(0, 2'b00, 0, 0, 0,            0, 0, 0, 2'b00, 4'b0001, 1, 0));
        vq.push_back(mk(1, 2'b11, 7, 32'h0,  32'h0,  6, 32'h0, 32'h0, 2'b00, 4'b0100, 7, 0));

        resetn = 1'b0;
        idle();
        #7;
        check("reset flags",   32'(flags()), 32'h0);
        check("reset err_at",  32'(err_at),  32'h0);
        check("reset pending", 32'(pending), 32'h0);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) begin
                pulse_reset();
            end
            drive(vq[i].vld, vq[i].o0, vq[i].pre0, vq[i].post0,
                  vq[i].o1, vq[i].pre1, vq[i].post1, vq[i].trap);
            step();
            check($sformatf("vec%0d flags", i),   32'(flags()), 32'(vq[i].eflags));
            check($sformatf("vec%0d err_at", i),  32'(err_at),  32'(vq[i].eat));
            check($sformatf("vec%0d pending", i), 32'(pending), 32'(vq[i].epend));
        end

        // Long in-order stream across the 8'hFF -> 8'h00 order wrap.
        idle();
        pulse_reset();
        for (int i = 0; i < 260; i++) begin
            drive(2'b01, 8'(i), 32'(4*i), 32'(4*i+4), 8'd0, 32'd0, 32'd0, 2'b00);
            step();
            if (i == 256) begin
                check("wrap pending", 32'(pending), 32'h1);
                check("wrap flags",   32'(flags()), 32'h0);
            end
        end
        idle();
        step();
        step();
        check("wrap end flags",   32'(flags()), 32'h0);
        check("wrap end pending", 32'(pending), 32'h0);

        // Asynchronous reset with slots pending and a flag raised.
        pulse_reset();
        drive(2'b01, 8'd0, 32'h0, 32'h4, 8'd0, 32'd0, 32'd0, 2'b00);
        step();
        drive(2'b01, 8'd2, 32'h8, 32'hC, 8'd0, 32'd0, 32'd0, 2'b00);
        step();
        drive(2'b11, 8'd3, 32'hC, 32'h10, 8'd9, 32'd0, 32'd0, 2'b00);
        step();
        drive(2'b01, 8'd4, 32'h10, 32'h14, 8'd0, 32'd0, 32'd0, 2'b00);
        step();
        idle();
        check("pre-reset pending",   32'(pending),   32'h3);
        check("pre-reset err_order", 32'(err_order), 32'h1);
        check("pre-reset err_at",    32'(err_at),    32'h9);
        resetn = 1'b0;
        #1;
        check("async reset pending", 32'(pending), 32'h0);
        check("async reset flags",   32'(flags()), 32'h0);
        check("async reset err_at",  32'(err_at),  32'h0);
        #1;
        resetn = 1'b1;
        drive(2'b01, 8'd0, 32'h777, 32'h77C, 8'd0, 32'd0, 32'd0, 2'b00);
        step();
        idle();
        step();
        check("post-reset err_pc",  32'(err_pc),  32'h0);
        check("post-reset flags",   32'(flags()), 32'h0);
        check("post-reset pending", 32'(pending), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvfi_pc_reorder_check.md
# rvfi_pc_reorder_check

Parametrised PC-continuity checker for RVFI traces that tolerates out-of-order retirement across `NRET` channels and across cycles. Retirements are captured into a reorder window indexed by `rvfi_order` and drained strictly in order. Each drained instruction's `pre_pc` is compared against the previous instruction's `post_pc`. The block sits beside the other RVFI checkers in the formal harness; it also exposes sticky error flags so simulation benches can use it.

## Interface

- `NRET`, 1: retirement channels.
- `XLEN`, 32: PC width.
- `ORDER_W`, 8: width of each `rvfi_order` field.
- `DEPTH`, 4: reorder window entries; power of two, `DEPTH <= 2**(ORDER_W-1)`.
- `IALIGN`, 4: required PC alignment in bytes, 2 or 4.

- `clk` in 1: clock.
- `resetn` in 1: asynchronous active-low reset.
- `rvfi_valid` in NRET: per-channel retire strobe.
- `rvfi_order` in NRET*ORDER_W: per-channel instruction index.
- `rvfi_pre_pc` in NRET*XLEN: PC before the instruction.
- `rvfi_post_pc` in NRET*XLEN: PC after the instruction.
- `rvfi_trap` in NRET: instruction trapped.
- `err_pc` out 1: sticky; PC chain broken.
- `err_order` out 1: sticky; order outside the window.
- `err_dup` out 1: sticky; order already buffered, or two channels with equal order.
- `err_align` out 1: sticky; a non-trapping `post_pc` is misaligned.
- `err_at` out ORDER_W: order of the first instruction that set any flag.
- `pending` out clog2(DEPTH+1): occupied window slots.

## Operation

- **State.**
  - `next_order` (ORDER_W) resets to 0.
  - `pc_shadow` (XLEN) resets to 0.
  - `pc_written` resets to 0.
  - Slot array: DEPTH entries of {`vld`, `pre_pc`, `post_pc`}, all `vld` reset to 0.
- **Capture.** For each channel with `rvfi_valid` set, compute `d = (order - next_order) mod 2**ORDER_W`.
  - `d >= DEPTH`: set `err_order`; entry discarded.
  - Slot `order[log2 DEPTH-1:0]` has `vld` set, or a lower-index channel wrote the same order this cycle: set `err_dup`; entry discarded, existing slot untouched.
  - Otherwise write the slot and set `vld`.
- **Alignment.** A captured entry with `rvfi_trap == 0` and `post_pc mod IALIGN != 0` sets `err_align` at capture. With `IALIGN == 2`, only bit 0 is checked.
- **Drain.** Each cycle, walk `k = 0..NRET-1` over slot `next_order+k` while `vld` is set; stop at the first empty slot.
  - If `pc_written` is set and `pc_shadow != pre_pc`: set `err_pc`.
  - Then `pc_shadow <= post_pc`, `pc_written <= 1`, clear the slot, and `next_order += 1` (wraps modulo 2**ORDER_W).
  - The chain is applied sequentially within a cycle, so the second entry is compared against the first entry's `post_pc`.
- **Error capture.** `err_at` latches the order of the first error event and freezes until reset. Among same-cycle events, the lowest channel wins, then the drain.
- **Pending count.** `pending` = slots written minus slots drained; updated every cycle.
- **Formal build.** Under `` `ifdef FORMAL ``, assert that all four error flags are 0.

## Timing

- A capture at edge t is drainable in the cycle after edge t. A slot written and drained in the same cycle is not allowed; the write-to-drain latency is 1 cycle.
- Error flags and `err_at` update on the edge that ends the detecting cycle.
- A write to a slot freed by a same-cycle drain is legal; the write wins.
- Full window: a new order with `d >= DEPTH` is an error, not a stall. The block never backpressures.
- Order wrap: `next_order = 8'hFF` with order `8'h00` gives `d = 1`, which is legal.
- Asynchronous reset mid-stream clears all state and flags immediately. The first drain after reset performs no PC compare.
- All outputs are 0 in reset.

## Structure

- Package `rvfi_check_pkg`:
  - slot typedef {`vld`, `pre_pc`, `post_pc`}, parameterised by XLEN through a localparam default;
  - `ORDER_W` default;
  - helper function `order_dist(a, b, w)`.
- One sub-module, `rvfi_order_window`, owns the slot array:
  - inputs: NRET write ports, drain-clear vector;
  - outputs: slot read of `next_order..next_order+NRET-1`.
- Chain compare, `next_order`/`pc_shadow` update and error logic stay in the top module.

## Test plan

- **In order, single channel.** NRET=1; orders 0,1,2 with pre/post 0→4, 4→8, 8→12 on consecutive cycles → no flags; `pending` returns to 0 two cycles after the last capture.
- **Out of order, two channels.** NRET=2; cycle 0: ch0 order 1 (4→8), ch1 order 0 (0→4) → both drain in one cycle; no flags; `next_order = 2`.
- **Break.** Orders 0 (0→4) then 1 with `pre_pc = 0x10` → `err_pc = 1`, `err_at = 1` two cycles after the order-1 capture.
- **Window and duplicate.** DEPTH=4, `next_order = 0`; order 4 → `err_order`. Order 2 sent twice → `err_dup`, and the first slot value is retained.
- **Wrap and alignment.** Drive the stream through order `8'hFF` → `8'h00` with no flags. Then a non-trap `post_pc = 0x1002` with IALIGN=4 → `err_align`. The same PC with `trap = 1` → no flag.
- **Reset mid-stream.** Assert `resetn = 0` with 3 slots pending → `pending = 0` and flags 0 immediately. Then order 0 with an arbitrary `pre_pc` → no `err_pc`.
